hazard_stall_ctrl: RTL and testbench

- Pipeline-control master that decides when the ID/EX register captures, bubbles or holds. It also gates PC and IF/ID.
- Reads the ID/EX outputs it needs (load flag, rt index) plus the ID-stage source registers, the EX branch result and the data-memory handshake.
- Resolves load-use hazards, taken-branch flushes and multi-cycle memory stalls through a small FSM.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard controller: load-use bubbles, branch flushes, memory freezes
// Mealy outputs in RUN so a hazard is acted on in the cycle it is detected; stall_cnt saturates.
module hazard_stall_ctrl #(
    parameter int LU_CYCLES       = 1,
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_Mread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_Write,
    output logic             IDEX_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_BRFLUSH = 2'd2,
        S_MEMWAIT = 2'd3
    } state_t;

    localparam logic [3:0] LU_INIT = (LU_CYCLES > 1) ? 4'(LU_CYCLES - 2) : 4'd0;
    localparam logic [3:0] BR_INIT = (BR_FLUSH_CYCLES > 1) ? 4'(BR_FLUSH_CYCLES - 2) : 4'd0;

    state_t           r_state;
    state_t           r_ret_state;
    logic [3:0]       r_count;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t     w_next_state;
    state_t     w_next_ret;
    state_t     w_eff_state;
    logic [3:0] w_next_count;
    logic       w_pc, w_ifw, w_iff, w_idw, w_idf;
    logic       w_mem_stall;
    logic       w_load_use;

    assign w_mem_stall = mem_req & ~mem_ack;
    assign w_load_use  = idex_Mread & (idex_rt != 5'd0) &
                         ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

    // The ack cycle of a memory wait behaves exactly like the state it interrupted.
    assign w_eff_state = (r_state == S_MEMWAIT && mem_ack) ? r_ret_state : r_state;

    always_comb begin
        w_pc         = 1'b1;
        w_ifw        = 1'b1;
        w_iff        = 1'b0;
        w_idw        = 1'b1;
        w_idf        = 1'b0;
        w_next_state = w_eff_state;
        w_next_ret   = r_ret_state;
        w_next_count = r_count;
        case (w_eff_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    w_pc         = 1'b0;
                    w_ifw        = 1'b0;
                    w_idw        = 1'b0;
                    w_next_state = S_MEMWAIT;
                    w_next_ret   = S_RUN;
                end else if (ex_branch_taken) begin
                    w_iff = 1'b1;
                    w_idf = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        w_next_state = S_BRFLUSH;
                        w_next_count = BR_INIT;
                    end
                end else if (w_load_use) begin
                    w_pc  = 1'b0;
                    w_ifw = 1'b0;
                    w_idf = 1'b1;
                    if (LU_CYCLES > 1) begin
                        w_next_state = S_LDSTALL;
                        w_next_count = LU_INIT;
                    end
                end
            end
            S_LDSTALL, S_BRFLUSH: begin
                if (w_mem_stall) begin
                    w_pc         = 1'b0;
                    w_ifw        = 1'b0;
                    w_idw        = 1'b0;
                    w_next_state = S_MEMWAIT;
                    w_next_ret   = w_eff_state;
                end else begin
                    if (w_eff_state == S_LDSTALL) begin
                        w_pc  = 1'b0;
                        w_ifw = 1'b0;
                    end else begin
                        w_iff = 1'b1;
                    end
                    w_idf = 1'b1;
                    if (r_count == 4'd0) begin
                        w_next_state = S_RUN;
                    end else begin
                        w_next_count = r_count - 4'd1;
                    end
                end
            end
            default: begin
                w_pc         = 1'b0;
                w_ifw        = 1'b0;
                w_idw        = 1'b0;
                w_next_state = S_MEMWAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_ret_state <= S_RUN;
            r_count     <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_count     <= w_next_count;
            if (!w_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign PC_write   = rst & w_pc;
    assign IFID_write = rst & w_ifw;
    assign IDEX_Write = rst & w_idw;
    assign IFID_flush = ~rst | w_iff;
    assign IDEX_flush = ~rst | w_idf;
    assign state      = r_state;
    assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - bench for hazard_stall_ctrl, two parameterisations driven in parallel
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt, idex_Mread, ex_branch_taken, mem_req, mem_ack;

    logic        a_pc, a_ifw, a_iff, a_idw, a_idf;
    logic [1:0]  a_state;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifw, b_iff, b_idw, b_idf;
    logic [1:0]  b_state;
    logic [2:0]  b_cnt;
    logic [4:0]  a_vec, b_vec;

    assign a_vec = {a_pc, a_ifw, a_iff, a_idw, a_idf};
    assign b_vec = {b_pc, b_ifw, b_iff, b_idw, b_idf};

    hazard_stall_ctrl #(.LU_CYCLES(1), .BR_FLUSH_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_Mread(idex_Mread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .PC_write(a_pc), .IFID_write(a_ifw),
        .IFID_flush(a_iff), .IDEX_Write(a_idw), .IDEX_flush(a_idf), .state(a_state), .stall_cnt(a_cnt)
    );

    hazard_stall_ctrl #(.LU_CYCLES(3), .BR_FLUSH_CYCLES(2), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_Mread(idex_Mread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .PC_write(b_pc), .IFID_write(b_ifw),
        .IFID_flush(b_iff), .IDEX_Write(b_idw), .IDEX_flush(b_idf), .state(b_state), .stall_cnt(b_cnt)
    );

    // Output vectors {PC_write, IFID_write, IFID_flush, IDEX_Write, IDEX_flush}
    localparam int V_RST    = 5;
    localparam int V_NORM   = 26;
    localparam int V_FREEZE = 0;
    localparam int V_BUBBLE = 3;
    localparam int V_FLUSH  = 31;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a memory wait flag, plus an ongoing multi-cycle action (1 = load-use, 2 = branch)
    // with the number of cycles it still has to run after the current one.
    int p_lu[2]  = '{1, 3};
    int p_br[2]  = '{1, 2};
    int p_sat[2] = '{65535, 7};
    int m_mem[2]  = '{0, 0};
    int m_kind[2] = '{0, 0};
    int m_left[2] = '{0, 0};
    int m_cnt[2]  = '{0, 0};

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int e_out, e_st, e_cnt, act_out, act_st, act_cnt, lu, waiting;
                act_out = (k == 0) ? int'(a_vec) : int'(b_vec);
                act_st  = (k == 0) ? int'(a_state) : int'(b_state);
                act_cnt = (k == 0) ? int'(a_cnt) : int'(b_cnt);
                lu = (idex_Mread && idex_rt != 0 &&
                      (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt))) ? 1 : 0;
                if (!rst) begin
                    e_out = V_RST; e_st = 0; e_cnt = 0;
                    m_mem[k] = 0; m_kind[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
                end else begin
                    e_st  = (m_mem[k] != 0) ? 3 : m_kind[k];
                    e_cnt = m_cnt[k];
                    waiting = (m_mem[k] != 0) ? !mem_ack : (mem_req && !mem_ack);
                    if (waiting != 0) begin
                        e_out = V_FREEZE;
                        m_mem[k] = 1;
                    end else begin
                        m_mem[k] = 0;
                        if (m_kind[k] != 0) begin
                            e_out = (m_kind[k] == 1) ? V_BUBBLE : V_FLUSH;
                            if (m_left[k] == 0) m_kind[k] = 0;
                            else m_left[k] = m_left[k] - 1;
                        end else if (ex_branch_taken) begin
                            e_out = V_FLUSH;
                            if (p_br[k] > 1) begin m_kind[k] = 2; m_left[k] = p_br[k] - 2; end
                        end else if (lu != 0) begin
                            e_out = V_BUBBLE;
                            if (p_lu[k] > 1) begin m_kind[k] = 1; m_left[k] = p_lu[k] - 2; end
                        end else begin
                            e_out = V_NORM;
                        end
                    end
                    if ((e_out & 16) == 0 && m_cnt[k] < p_sat[k]) m_cnt[k] = m_cnt[k] + 1;
                end
                chk($sformatf("model_outs[u%0d]", k), act_out, e_out);
                chk($sformatf("model_state[u%0d]", k), act_st, e_st);
                chk($sformatf("model_cnt[u%0d]", k), act_cnt, e_cnt);
            end
        end
    end

    task automatic quiet();
        ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0; idex_Mread = 1'b0;
        idex_rt = 5'd0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        quiet();
        repeat (3) cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        quiet();
        chk_en = 1'b1;
        #3;
        chk("rst_outs_a", a_vec, V_RST);
        chk("rst_outs_b", b_vec, V_RST);
        repeat (3) cyc();
        rst = 1'b1;
        #2;
        chk("post_rst_outs", a_vec, V_NORM);
        chk("post_rst_state", a_state, 0);
        chk("post_rst_cnt", a_cnt, 0);

        // Load-use via rs, single-cycle on u_a
        cyc();
        idex_Mread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        #2 chk("lu_rs_a", a_vec, V_BUBBLE);
        cyc();
        quiet();
        #2 chk("lu_rs_after_a", a_vec, V_NORM);
        chk("lu_rs_cnt_a", a_cnt, 1);
        repeat (3) cyc();
        chk("lu_rs_cnt_b", b_cnt, 3);
        idex_Mread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        #2 chk("lu_r0_a", a_vec, V_NORM);
        cyc();
        quiet();

        // Load-use via rt, three cycles on u_b
        do_reset();
        idex_Mread = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; ifid_uses_rt = 1'b1; ifid_rs = 5'd2;
        #2 chk("lu_rt_c1", b_vec, V_BUBBLE);
        chk("lu_rt_c1_st", b_state, 0);
        cyc();
        quiet();
        #2 chk("lu_rt_c2", b_vec, V_BUBBLE);
        chk("lu_rt_c2_st", b_state, 1);
        cyc();
        #2 chk("lu_rt_c3", b_vec, V_BUBBLE);
        chk("lu_rt_c3_st", b_state, 1);
        cyc();
        #2 chk("lu_rt_done", b_vec, V_NORM);
        chk("lu_rt_done_st", b_state, 0);
        chk("lu_rt_cnt", b_cnt, 3);
        idex_Mread = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; ifid_uses_rt = 1'b0; ifid_rs = 5'd3;
        #2 chk("lu_rt_unused", b_vec, V_NORM);
        cyc();
        quiet();

        // Branch beats a simultaneous load-use
        do_reset();
        ex_branch_taken = 1'b1; idex_Mread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        #2 chk("br_c1_b", b_vec, V_FLUSH);
        chk("br_c1_a", a_vec, V_FLUSH);
        cyc();
        quiet();
        #2 chk("br_c2_b", b_vec, V_FLUSH);
        chk("br_c2_st", b_state, 2);
        chk("br_c2_a", a_vec, V_NORM);
        cyc();
        #2 chk("br_done_b", b_vec, V_NORM);
        chk("br_cnt_b", b_cnt, 0);
        chk("br_cnt_a", a_cnt, 0);

        // Memory wait, branch held during the wait acted on at ack
        do_reset();
        mem_req = 1'b1; mem_ack = 1'b0;
        #2 chk("mem_c1", a_vec, V_FREEZE);
        chk("mem_c1_st", a_state, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i >= 1) ex_branch_taken = 1'b1;
            #2 chk("mem_wait", a_vec, V_FREEZE);
            chk("mem_wait_st", a_state, 3);
        end
        cyc();
        mem_ack = 1'b1;
        #2 chk("mem_ack", a_vec, V_FLUSH);
        chk("mem_ack_st", a_state, 3);
        cyc();
        quiet();
        #2 chk("mem_exit", a_vec, V_NORM);
        chk("mem_exit_st", a_state, 0);
        chk("mem_cnt_a", a_cnt, 4);
        chk("mem_br_b", b_vec, V_FLUSH);
        chk("mem_br_st_b", b_state, 2);
        chk("mem_cnt_b", b_cnt, 4);
        cyc();

        // Memory stall interrupting LDSTALL resumes the countdown after ack
        do_reset();
        idex_Mread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
        cyc();
        quiet();
        mem_req = 1'b1;
        #2 chk("ld_mem_freeze", b_vec, V_FREEZE);
        chk("ld_mem_st", b_state, 1);
        cyc();
        cyc();
        mem_ack = 1'b1;
        #2 chk("ld_mem_ack", b_vec, V_BUBBLE);
        chk("ld_mem_ack_a", a_vec, V_NORM);
        cyc();
        quiet();
        #2 chk("ld_resume", b_vec, V_BUBBLE);
        chk("ld_resume_st", b_state, 1);
        cyc();
        #2 chk("ld_resume_done", b_vec, V_NORM);
        chk("ld_resume_cnt_b", b_cnt, 5);
        chk("ld_resume_cnt_a", a_cnt, 3);

        // Saturation, then reset abort mid-wait
        do_reset();
        mem_req = 1'b1; mem_ack = 1'b0;
        repeat (10) cyc();
        chk("sat_b", b_cnt, 7);
        chk("nosat_a", a_cnt, 10);
        chk("sat_st", a_state, 3);
        rst = 1'b0;
        quiet();
        #2 chk("abort_st", a_state, 0);
        chk("abort_cnt", a_cnt, 0);
        chk("abort_outs", a_vec, V_RST);
        cyc();
        rst = 1'b1;
        #2 chk("abort_run", a_vec, V_NORM);
        chk("abort_run_b", b_vec, V_NORM);
        repeat (3) cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
